wave_capture: RTL

- Acquisition-side writer for the waveform display path. Sits in the I_wave_clk domain between the ADC sample stream and the wave buffer write port.
- Decimates incoming ADC samples and detects the trigger crossing (level plus rising/falling edge).
- Emits exactly one screen-width burst of samples with data-valid per trigger. Supports auto-trigger timeout, single-shot mode and holdoff.

---
 rtl/wave_capture.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wave_capture.sv
// Acquisition-side writer: decimates the ADC stream, finds the trigger crossing and
// writes one DEPTH-sample burst per trigger into the wave buffer.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_ARMED   | waiting for a level crossing (or the auto-trigger timeout)
// ST_CAPTURE | writing kept samples, indices 1..DEPTH-1
// ST_HOLDOFF | dead time between bursts in continuous mode
// ST_DONE    | single-shot burst finished, waiting for I_arm
module wave_capture #(
    parameter int DEPTH        = 750,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int HOLDOFF      = 1024
) (
    input  logic       I_wave_clk,
    input  logic       I_wave_rstn,
    input  logic [7:0] I_adc_data,
    input  logic       I_adc_valid,
    input  logic [7:0] I_decim,
    input  logic [7:0] I_trig_level,
    input  logic       trigger_edge,
    input  logic       single_flag,
    input  logic       I_auto_en,
    input  logic       I_arm,
    output logic [7:0] O_wave_data,
    output logic       O_wave_data_de,
    output logic       O_frame_start,
    output logic       O_auto_flag,
    output logic       O_done
);

    localparam int TW = $clog2(AUTO_TIMEOUT);
    localparam int HW = $clog2(HOLDOFF);

    typedef enum logic [1:0] {ST_ARMED, ST_CAPTURE, ST_HOLDOFF, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      dec_cnt_q, dec_cnt_d;
    logic [7:0]      decim_q, decim_d;
    logic [7:0]      prev_q, prev_d;
    logic            prev_valid_q, prev_valid_d;
    logic [TW-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [9:0]      wr_cnt_q, wr_cnt_d;
    logic [7:0]      data_q, data_d;
    logic            de_q, de_d;
    logic            frame_q, frame_d;
    logic            auto_q, auto_d;

    logic            s_keep;
    logic [7:0]      period;
    logic            rise_hit, fall_hit, trig_hit, timeout_hit;

    // The decimation ratio is sampled on each kept sample so a new I_decim
    // only changes the period from the next wrap onwards.
    assign s_keep      = I_adc_valid && (dec_cnt_q == 8'd0);
    assign period      = (dec_cnt_q == 8'd0) ? I_decim : decim_q;
    assign rise_hit    = (prev_q < I_trig_level) && (I_adc_data >= I_trig_level);
    assign fall_hit    = (prev_q > I_trig_level) && (I_adc_data <= I_trig_level);
    assign trig_hit    = prev_valid_q && (trigger_edge ? fall_hit : rise_hit);
    assign timeout_hit = I_auto_en && (timeout_cnt_q == TW'(AUTO_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        dec_cnt_d     = dec_cnt_q;
        decim_d       = decim_q;
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
        timeout_cnt_d = timeout_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        data_d        = data_q;
        de_d          = 1'b0;
        frame_d       = 1'b0;
        auto_d        = auto_q;

        if (I_adc_valid) begin
            if (dec_cnt_q == 8'd0) begin
                decim_d = I_decim;
            end
            dec_cnt_d = (dec_cnt_q == period) ? 8'd0 : dec_cnt_q + 8'd1;
        end

        if (!I_auto_en) begin
            timeout_cnt_d = '0;
        end

        case (state_q)
            ST_ARMED: begin
                if (s_keep) begin
                    if (trig_hit || timeout_hit) begin
                        data_d   = I_adc_data;
                        de_d     = 1'b1;
                        frame_d  = 1'b1;
                        auto_d   = timeout_hit && !trig_hit;
                        wr_cnt_d = 10'd1;
                        state_d  = ST_CAPTURE;
                    end else begin
                        prev_d       = I_adc_data;
                        prev_valid_d = 1'b1;
                        if (I_auto_en) begin
                            timeout_cnt_d = timeout_cnt_q + TW'(1);
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (s_keep) begin
                    data_d = I_adc_data;
                    de_d   = 1'b1;
                    if (wr_cnt_q == 10'(DEPTH - 1)) begin
                        wr_cnt_d = 10'd0;
                        state_d  = single_flag ? ST_DONE : ST_HOLDOFF;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 10'd1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == HW'(HOLDOFF - 1)) begin
                    hold_cnt_d = '0;
                    if (single_flag) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d       = ST_ARMED;
                        prev_valid_d  = 1'b0;
                        timeout_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_DONE: begin
                if (I_arm) begin
                    state_d       = ST_ARMED;
                    prev_valid_d  = 1'b0;
                    timeout_cnt_d = '0;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    always_ff @(posedge I_wave_clk or negedge I_wave_rstn) begin
        if (!I_wave_rstn) begin
            state_q       <= ST_ARMED;
            dec_cnt_q     <= 8'd0;
            decim_q       <= 8'd0;
            prev_q        <= 8'd0;
            prev_valid_q  <= 1'b0;
            timeout_cnt_q <= '0;
            hold_cnt_q    <= '0;
            wr_cnt_q      <= 10'd0;
            data_q        <= 8'd0;
            de_q          <= 1'b0;
            frame_q       <= 1'b0;
            auto_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_cnt_q     <= dec_cnt_d;
            decim_q       <= decim_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            timeout_cnt_q <= timeout_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            data_q        <= data_d;
            de_q          <= de_d;
            frame_q       <= frame_d;
            auto_q        <= auto_d;
        end
    end

    assign O_wave_data    = data_q;
    assign O_wave_data_de = de_q;
    assign O_frame_start  = frame_q;
    assign O_auto_flag    = auto_q;
    assign O_done         = (state_q == ST_DONE);

endmodule
